// File: rtl/controle_sprites.sv
// Sprite-position controller: cursor moves, robot stepping, trash collection.
// Ports: Clock/Reset, v_sync (active-low), 5 buttons, packed sprite buses out.
// Outputs: ColunasSprites/LinhasSprites, Atualizado pulse, Ocupado busy flag.
module controle_sprites #(
  parameter int unsigned MOVE_FRAMES = 4,
  parameter logic [8:0] PRETA_INI  = {5'd19, 4'd4},
  parameter logic [8:0] LIXO1_INI  = {5'd4, 4'd5},
  parameter logic [8:0] LIXO2_INI  = {5'd16, 4'd6},
  parameter logic [8:0] LIXO3_INI  = {5'd18, 4'd4},
  parameter logic [8:0] ROBO_INI   = {5'd0, 4'd0},
  parameter logic [8:0] CURSOR_INI = {5'd0, 4'd0}
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        v_sync,
  input  logic        Cima,
  input  logic        Baixo,
  input  logic        Esquerda,
  input  logic        Direita,
  input  logic        Confirma,
  output logic [29:0] ColunasSprites,
  output logic [23:0] LinhasSprites,
  output logic        Atualizado,
  output logic        Ocupado
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    BLOQ
  } st_t;

  localparam logic [3:0] LAST   = 4'(MOVE_FRAMES - 1);
  localparam logic [8:0] PARKED = {5'h1F, 4'hF};
  localparam logic [4:0] COL_MAX = 5'd19;
  localparam logic [3:0] LIN_MAX = 4'd14;

  // Button vector order: {Cima, Baixo, Esquerda, Direita, Confirma}
  logic [4:0] btn_i;
  assign btn_i = {Cima, Baixo, Esquerda, Direita, Confirma};

  logic [4:0] s1_q, s2_q, s3_q, edge_q, pend_q;
  logic       vs1_q, vs2_q, vs3_q, tick_q;

  logic [8:0] cur_q, cur_d;
  logic [8:0] rob_q, rob_d;
  logic [8:0] tgt_q, tgt_d;
  logic [8:0] lx1_q, lx1_d;
  logic [8:0] lx2_q, lx2_d;
  logic [8:0] lx3_q, lx3_d;
  logic [8:0] cand;
  logic [3:0] cnt_q, cnt_d;
  st_t        st_q, st_d;
  logic       step;
  logic       upd_q, ocup_q;

  logic pu, pd, pl, pr, pc;
  assign {pu, pd, pl, pr, pc} = pend_q;

  // Synchronizers and edge detectors; v_sync idles high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      edge_q <= '0;
      pend_q <= '0;
      vs1_q  <= 1'b1;
      vs2_q  <= 1'b1;
      vs3_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= s2_q & ~s3_q;
      vs1_q  <= v_sync;
      vs2_q  <= vs1_q;
      vs3_q  <= vs2_q;
      tick_q <= vs3_q & ~vs2_q;
      // An edge landing with the tick belongs to the next frame.
      if (tick_q) pend_q <= edge_q;
      else        pend_q <= pend_q | edge_q;
    end
  end

  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    rob_d = rob_q;
    lx1_d = lx1_q;
    lx2_d = lx2_q;
    lx3_d = lx3_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    step  = 1'b0;
    cand  = rob_q;
    if (tick_q) begin
      // Cursor: opposite directions cancel per axis.
      if (pl && !pr && cur_q[8:4] != 5'd0)
        cur_d[8:4] = cur_q[8:4] - 5'd1;
      else if (pr && !pl && cur_q[8:4] != COL_MAX)
        cur_d[8:4] = cur_q[8:4] + 5'd1;
      if (pu && !pd && cur_q[3:0] != 4'd0)
        cur_d[3:0] = cur_q[3:0] - 4'd1;
      else if (pd && !pu && cur_q[3:0] != LIN_MAX)
        cur_d[3:0] = cur_q[3:0] + 4'd1;

      if (pc) begin
        tgt_d = cur_d;
        if (st_q != MOVE) begin
          st_d  = MOVE;
          cnt_d = 4'd0;
        end
      end

      if (st_d == MOVE) begin
        if (cnt_d == LAST) begin
          cnt_d = 4'd0;
          step  = 1'b1;
        end else begin
          cnt_d = cnt_d + 4'd1;
        end
      end

      if (step) begin
        // Column first, line only once columns agree.
        if (rob_q[8:4] < tgt_d[8:4])
          cand[8:4] = rob_q[8:4] + 5'd1;
        else if (rob_q[8:4] > tgt_d[8:4])
          cand[8:4] = rob_q[8:4] - 5'd1;
        else if (rob_q[3:0] < tgt_d[3:0])
          cand[3:0] = rob_q[3:0] + 4'd1;
        else if (rob_q[3:0] > tgt_d[3:0])
          cand[3:0] = rob_q[3:0] - 4'd1;

        if (rob_q == tgt_d) begin
          st_d = IDLE;
        end else if (cand == PRETA_INI) begin
          st_d = BLOQ;
        end else begin
          rob_d = cand;
          if (cand == tgt_d) st_d = IDLE;
        end

        if (lx1_q != PARKED && rob_d == lx1_q) lx1_d = PARKED;
        if (lx2_q != PARKED && rob_d == lx2_q) lx2_d = PARKED;
        if (lx3_q != PARKED && rob_d == lx3_q) lx3_d = PARKED;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cur_q  <= CURSOR_INI;
      rob_q  <= ROBO_INI;
      tgt_q  <= ROBO_INI;
      lx1_q  <= LIXO1_INI;
      lx2_q  <= LIXO2_INI;
      lx3_q  <= LIXO3_INI;
      cnt_q  <= 4'd0;
      st_q   <= IDLE;
      upd_q  <= 1'b0;
      ocup_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      rob_q  <= rob_d;
      tgt_q  <= tgt_d;
      lx1_q  <= lx1_d;
      lx2_q  <= lx2_d;
      lx3_q  <= lx3_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      upd_q  <= tick_q;
      ocup_q <= (st_d != IDLE);
    end
  end

  assign ColunasSprites = {PRETA_INI[8:4], lx1_q[8:4], lx2_q[8:4],
                           lx3_q[8:4], rob_q[8:4], cur_q[8:4]};
  assign LinhasSprites  = {PRETA_INI[3:0], lx1_q[3:0], lx2_q[3:0],
                           lx3_q[3:0], rob_q[3:0], cur_q[3:0]};
  assign Atualizado = upd_q;
  assign Ocupado    = ocup_q;

endmodule

// File: tb/tb_controle_sprites.sv
// Directed bench for controle_sprites: cursor, robot path, collection,
// blocked cell and asynchronous reset.
module tb_controle_sprites;

  logic        Clock = 1'b0;
  logic        Reset, v_sync;
  logic        Cima, Baixo, Esquerda, Direita, Confirma;
  logic [29:0] Col;
  logic [23:0] Lin;
  logic        Atualizado, Ocupado;

  int errs = 0;
  int nchk = 0;

  localparam logic [4:0] U = 5'b10000;
  localparam logic [4:0] D = 5'b01000;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] R = 5'b00010;
  localparam logic [4:0] C = 5'b00001;

  localparam logic [29:0] RST_COL =
    {5'd19, 5'd4, 5'd16, 5'd18, 5'd0, 5'd0};
  localparam logic [23:0] RST_LIN =
    {4'd4, 4'd5, 4'd6, 4'd4, 4'd0, 4'd0};
  localparam logic [8:0] PARK = {5'h1F, 4'hF};

  always #20 Clock = ~Clock;

  controle_sprites dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .v_sync        (v_sync),
    .Cima          (Cima),
    .Baixo         (Baixo),
    .Esquerda      (Esquerda),
    .Direita       (Direita),
    .Confirma      (Confirma),
    .ColunasSprites(Col),
    .LinhasSprites (Lin),
    .Atualizado    (Atualizado),
    .Ocupado       (Ocupado)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] cur();
    return {Col[4:0], Lin[3:0]};
  endfunction
  function automatic logic [8:0] rob();
    return {Col[9:5], Lin[7:4]};
  endfunction
  function automatic logic [8:0] lx3();
    return {Col[14:10], Lin[11:8]};
  endfunction
  function automatic logic [8:0] lx2();
    return {Col[19:15], Lin[15:12]};
  endfunction
  function automatic logic [8:0] lx1();
    return {Col[24:20], Lin[19:16]};
  endfunction

  task automatic press(input logic [4:0] m);
    @(negedge Clock);
    {Cima, Baixo, Esquerda, Direita, Confirma} = m;
    repeat (3) @(negedge Clock);
    {Cima, Baixo, Esquerda, Direita, Confirma} = 5'b0;
    repeat (4) @(negedge Clock);
  endtask

  task automatic frame();
    @(negedge Clock);
    v_sync = 1'b0;
    repeat (6) @(negedge Clock);
    v_sync = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic mv(input logic [4:0] m, input int n);
    repeat (n) begin
      press(m);
      frame();
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (Ocupado && k < 100) begin
      frame();
      k++;
    end
    chk(tag, Ocupado, 0);
  endtask

  initial begin
    int seen;
    Reset = 1'b1;
    v_sync = 1'b1;
    {Cima, Baixo, Esquerda, Direita, Confirma} = 5'b0;
    repeat (3) @(negedge Clock);
    chk("rst_col", Col, RST_COL);
    chk("rst_lin", Lin, RST_LIN);
    chk("rst_atu", Atualizado, 0);
    chk("rst_ocup", Ocupado, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    // First move with latency check
    press(R);
    @(negedge Clock);
    v_sync = 1'b0;
    repeat (3) @(negedge Clock);
    chk("atu_early", Atualizado, 0);
    @(negedge Clock);
    chk("atu_pulse", Atualizado, 1);
    chk("r1_col", Col, {RST_COL[29:5], 5'd1});
    chk("r1_lin", Lin, RST_LIN);
    @(negedge Clock);
    chk("atu_once", Atualizado, 0);
    v_sync = 1'b1;
    repeat (4) @(negedge Clock);

    // Saturation and cancel
    mv(R, 18);
    chk("cur_19_0", cur(), {5'd19, 4'd0});
    mv(R | U, 1);
    chk("sat_ru", cur(), {5'd19, 4'd0});
    mv(L | R, 1);
    chk("cancel_lr", cur(), {5'd19, 4'd0});
    mv(L | D, 1);
    chk("diag", cur(), {5'd18, 4'd1});
    mv(L, 16);
    chk("cur_2_1", cur(), {5'd2, 4'd1});

    // Robot path to {2,1}
    press(C);
    frame();
    chk("busy_on", Ocupado, 1);
    frames(2);
    chk("rob_f3", rob(), {5'd0, 4'd0});
    frame();
    chk("rob_f4", rob(), {5'd1, 4'd0});
    frames(3);
    chk("rob_f7", rob(), {5'd1, 4'd0});
    frame();
    chk("rob_f8", rob(), {5'd2, 4'd0});
    frames(3);
    chk("busy_f11", Ocupado, 1);
    frame();
    chk("rob_f12", rob(), {5'd2, 4'd1});
    chk("busy_off", Ocupado, 0);

    // Collection of trash 1
    mv(D, 4);
    press(C);
    frame();
    wait_idle("idle_2_5");
    chk("rob_2_5", rob(), {5'd2, 4'd5});
    chk("lx1_keep", lx1(), {5'd4, 4'd5});
    mv(R, 3);
    press(C);
    frame();
    frames(6);
    chk("rob_3_5", rob(), {5'd3, 4'd5});
    chk("lx1_pre", lx1(), {5'd4, 4'd5});
    frame();
    chk("rob_4_5", rob(), {5'd4, 4'd5});
    chk("lx1_park", lx1(), PARK);
    frames(4);
    chk("rob_5_5", rob(), {5'd5, 4'd5});
    chk("idle_5_5", Ocupado, 0);

    // Blocked cell
    mv(R, 13);
    mv(U, 1);
    chk("cur_18_4", cur(), {5'd18, 4'd4});
    press(C);
    frame();
    wait_idle("idle_18_4");
    chk("rob_18_4", rob(), {5'd18, 4'd4});
    chk("lx3_park", lx3(), PARK);
    chk("lx2_keep", lx2(), {5'd16, 4'd6});
    mv(R, 1);
    press(C);
    frame();
    frames(3);
    chk("bloq_rob", rob(), {5'd18, 4'd4});
    chk("bloq_busy", Ocupado, 1);
    frames(4);
    chk("bloq_hold", Ocupado, 1);
    chk("bloq_rob2", rob(), {5'd18, 4'd4});
    chk("preta", {Col[29:25], Lin[23:20]}, {5'd19, 4'd4});
    press(L | C);
    frame();
    frames(2);
    chk("self_busy", Ocupado, 1);
    frame();
    chk("self_idle", Ocupado, 0);
    chk("self_rob", rob(), {5'd18, 4'd4});

    // Reset mid-move
    mv(L, 1);
    press(C);
    frame();
    frame();
    chk("mid_busy", Ocupado, 1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("arst_col", Col, RST_COL);
    chk("arst_lin", Lin, RST_LIN);
    chk("arst_ocup", Ocupado, 0);
    chk("arst_atu", Atualizado, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge Clock);
      if (Atualizado) seen++;
    end
    chk("no_upd", seen, 0);
    press(R);
    frame();
    chk("post_cur", cur(), {5'd1, 4'd0});
    chk("post_rob", rob(), {5'd0, 4'd0});

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/controle_sprites.md
# controle_sprites

Sprite-position controller upstream of the graphics stage. It turns player button presses into cursor moves, drives the robot step-by-step toward a confirmed target, and removes trash items the robot lands on. It publishes the packed `ColunasSprites`/`LinhasSprites` buses only at frame boundaries, so the graphics stage sees positions that are stable for a whole frame. The playfield is a 20-column × 15-line grid of 32×32 cells.

## Interface
Parameters:
- `MOVE_FRAMES`, 4: frames between consecutive robot steps (1..15).
- `PRETA_INI`, {5'd19,4'd4}: black (blocked) cell, {col,line}.
- `LIXO1_INI`, {5'd4,4'd5}: initial position of trash 1.
- `LIXO2_INI`, {5'd16,4'd6}: initial position of trash 2.
- `LIXO3_INI`, {5'd18,4'd4}: initial position of trash 3.
- `ROBO_INI`, {5'd0,4'd0}: robot reset position.
- `CURSOR_INI`, {5'd0,4'd0}: cursor reset position.

Ports:
- `Clock` in 1: pixel clock (25 MHz).
- `Reset` in 1: asynchronous, active-high.
- `v_sync` in 1: vertical sync from the VGA interface, active-low; its falling edge marks the frame boundary.
- `Cima`, `Baixo`, `Esquerda`, `Direita` in 1 each: button levels, asynchronous to `Clock`.
- `Confirma` in 1: button level, asynchronous; sets the robot target to the cursor.
- `ColunasSprites` out 30: {Preta, Lixo1, Lixo2, Lixo3, Robo, Cursor} columns, 5 bits each, MSB first.
- `LinhasSprites` out 24: same order, line fields, 4 bits each.
- `Atualizado` out 1: one-cycle pulse in the cycle the output buses change.
- `Ocupado` out 1: high while the robot FSM is not in IDLE.

## Operation
- Input conditioning: each button and `v_sync` passes through a 2-flop synchronizer followed by a rising-edge detector. For `v_sync`, the detector looks for the falling edge.
- Each detected button edge sets a sticky pending flag. All pending flags clear at the frame tick.
- Frame tick processing order, all in one cycle:
  1. Cursor moves.
  2. Confirm is applied.
  3. The robot step counter runs.
  4. Collection is applied.
- Cursor moves:
  - Vertical: `Cima` decrements the line; `Baixo` increments it.
  - Horizontal: `Esquerda` decrements the column; `Direita` increments it.
  - Moves saturate at column 0..19 and line 0..14.
  - Opposite directions pending together cancel on that axis. Axes are independent, so diagonal moves are allowed.
- Confirm: sets target = new cursor position. If FSM = IDLE or BLOQ, it goes to MOVE with step counter = 0. If already in MOVE, the target is replaced and the counter is kept.
- Robot FSM states:
  - IDLE: robot at rest.
  - MOVE: each frame tick increments the step counter. When counter = MOVE_FRAMES-1, the counter resets and the robot takes one step:
    - The column is corrected first (±1 toward the target column).
    - The line is corrected only once the columns match.
    - If the candidate cell equals Preta, the robot does not move and the FSM goes to BLOQ.
    - If the robot reaches the target after the step, the FSM goes to IDLE.
  - BLOQ: holds until the next Confirm.
- Collection: after a step, if the robot position equals any Lixo position, that Lixo's field becomes parked {5'h1F,4'hF}. Parked items never match again.
- Confirm with target = robot position: FSM goes to MOVE, then to IDLE at the first step slot with no movement.

## Timing
- Frame tick is asserted 3 cycles after the `v_sync` falling edge: 2 synchronizer cycles plus 1 edge-detect cycle.
- Internal state and the output registers update on the cycle after the tick. `Atualizado` pulses in that same cycle.
- Outputs are constant between updates, including through the whole active video region.
- Button latency: a press is visible on the outputs at the first frame update after its synchronized edge.
  - An edge detected in the same cycle as the tick is kept for the next frame.
  - Only the flags captured before the tick are consumed.
- Repeated presses of one direction within one frame count as a single move.
- Reset values:
  - ColunasSprites = {PRETA,LIXO1,LIXO2,LIXO3,ROBO,CURSOR} column fields of the parameters.
  - LinhasSprites = the corresponding line fields.
  - Atualizado = 0, Ocupado = 0, FSM = IDLE, step counter = 0, all pending flags cleared.
- Reset mid-move: all outputs return to the reset values at once (asynchronous). No partial frame update follows.
- `Ocupado` is registered and changes in the same cycle as the outputs.

## Test plan
- Reset, then `Direita` pulse, then `v_sync` falling edge -> `Atualizado` 4 cycles after the edge; cursor column 0→1; all other fields unchanged.
- Cursor at col 19, `Direita`+`Cima` at line 0 -> cursor stays at {19,0}; `Esquerda`+`Direita` together -> column unchanged.
- Cursor at {2,1}, `Confirma`, MOVE_FRAMES=4 -> robot {1,0} after frame 4, {2,0} after frame 8, {2,1} after frame 12; `Ocupado` falls with that last update.
- Target {5,5}, robot path crosses Lixo1 at {4,5} -> LIXO1 field becomes {1F,F} in the same update the robot reaches {4,5}.
- Robot {18,4}, target {19,4} (Preta) -> robot stays at {18,4}; state BLOQ; `Ocupado`=1 until the next `Confirma` with a new target.
- `Reset` asserted while in MOVE -> outputs equal the reset parameters immediately; no `Atualizado` until the next `v_sync` edge following a press.
